pq_min_scanner: RTL and testbench

//  Control stage directly downstream of the priority-queue comparison counter.

---
 rtl/pq_min_scanner.sv | 129 ++++++++++++
 tb/tb_pq_min_scanner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_min_scanner.sv
// pq_min_scanner: drives the comparison counter, scans key RAM 1..15 for the minimum valid key.
// Optional: define PQ_SCAN_COUNT_EN to add res_count (number of occupied entries seen).
module pq_min_scanner #(
    parameter int W  = 4,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic [W-1:0]  cnt_q,
    input  logic          cnt_last,
    output logic          cnt_enb,
    output logic          cnt_clr,
    output logic          rd_en,
    output logic [W-1:0]  rd_addr,
    input  logic [KW-1:0] rd_key,
    input  logic          rd_vld,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [KW-1:0] res_key,
    output logic [W-1:0]  res_idx,
`ifdef PQ_SCAN_COUNT_EN
    output logic [W-1:0]  res_count,
`endif
    output logic          res_empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic          pend_q;
    logic [W-1:0]  addr_q;
    logic [KW-1:0] min_q;
    logic [W-1:0]  idx_q;
    logic          found_q;
    logic          go;
    logic          hit;

    assign go  = (state == IDLE) && start;
    // Strict compare on ascending addresses keeps the lower index on ties.
    assign hit = pend_q && rd_vld && (rd_key < min_q);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (cnt_last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from state and counter index.
    always_comb begin
        busy      = (state != IDLE);
        cnt_clr   = go;
        rd_en     = (state == SCAN);
        cnt_enb   = (state == SCAN) && !cnt_last;
        rd_addr   = (state == SCAN) ? cnt_q : '0;
        res_valid = (state == DONE);
        res_empty = (state == DONE) && !found_q;
        res_key   = min_q;
        res_idx   = idx_q;
    end

    // Read pipeline: remember which address has data due next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            pend_q <= rd_en;
            addr_q <= rd_addr;
        end
    end

    // Running minimum, cleared when a scan is launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q   <= '1;
            idx_q   <= '0;
            found_q <= 1'b0;
        end else if (go) begin
            min_q   <= '1;
            idx_q   <= '0;
            found_q <= 1'b0;
        end else if (hit) begin
            min_q   <= rd_key;
            idx_q   <= addr_q;
            found_q <= 1'b1;
        end
    end

`ifdef PQ_SCAN_COUNT_EN
    logic [W-1:0] count_q;

    // Occupied-entry tally for the current scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (go) begin
            count_q <= '0;
        end else if (pend_q && rd_vld) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign res_count = count_q;
`endif

endmodule

// File: tb/tb_pq_min_scanner.sv
// tb_pq_min_scanner: scoreboard bench with counter and key-RAM models.
// Define PQ_SCAN_COUNT_EN to also check res_count.
module tb_pq_min_scanner;

    localparam int W  = 4;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [W-1:0]  cnt_q;
    logic          cnt_last;
    logic          cnt_enb;
    logic          cnt_clr;
    logic          rd_en;
    logic [W-1:0]  rd_addr;
    logic [KW-1:0] rd_key;
    logic          rd_vld;
    logic          res_valid;
    logic          res_ready;
    logic [KW-1:0] res_key;
    logic [W-1:0]  res_idx;
    logic          res_empty;
`ifdef PQ_SCAN_COUNT_EN
    logic [W-1:0]  res_count;
`endif

    pq_min_scanner #(.W(W), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .cnt_q     (cnt_q),
        .cnt_last  (cnt_last),
        .cnt_enb   (cnt_enb),
        .cnt_clr   (cnt_clr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_key    (rd_key),
        .rd_vld    (rd_vld),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_key   (res_key),
        .res_idx   (res_idx),
`ifdef PQ_SCAN_COUNT_EN
        .res_count (res_count),
`endif
        .res_empty (res_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparison counter model.
    always @(posedge clk or negedge rst) begin
        if (!rst)         cnt_q <= '0;
        else if (cnt_clr) cnt_q <= 4'd1;
        else if (cnt_enb) cnt_q <= cnt_q + 4'd1;
    end
    assign cnt_last = (cnt_q == 4'd15) || (cnt_q == 4'd0);

    // Key RAM model; idle cycles return a bogus occupied zero key.
    logic [KW-1:0] mem_key [16];
    logic          mem_vld [16];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_key <= mem_key[rd_addr];
            rd_vld <= mem_vld[rd_addr];
        end else begin
            rd_key <= 8'h00;
            rd_vld <= 1'b1;
        end
    end

    typedef struct {
        logic [KW-1:0] key;
        logic [W-1:0]  idx;
        logic          empty;
        logic [W-1:0]  count;
        int            start_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: checks each result against the scoreboard and holds it stable.
    logic          in_done = 1'b0;
    logic [KW-1:0] hk;
    logic [W-1:0]  hi;
    logic          he;
    always @(negedge clk) begin
        if (!rst) begin
            in_done = 1'b0;
        end else if (res_valid) begin
            if (!in_done) begin
                in_done = 1'b1;
                hk = res_key;
                hi = res_idx;
                he = res_empty;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got key %0h idx %0h, none expected",
                             res_key, res_idx);
                end else begin
                    chk("latency", cyc - sb[0].start_cyc, 17);
                    chk("res_key", res_key, sb[0].key);
                    chk("res_idx", res_idx, sb[0].idx);
                    chk("res_empty", res_empty, sb[0].empty);
`ifdef PQ_SCAN_COUNT_EN
                    chk("res_count", res_count, sb[0].count);
`endif
                end
            end else begin
                chk("hold_key", res_key, hk);
                chk("hold_idx", res_idx, hi);
                chk("hold_empty", res_empty, he);
            end
            if (res_ready) begin
                in_done = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic vld, input logic [KW-1:0] key);
        for (int i = 0; i < 16; i++) begin
            mem_key[i] = key;
            mem_vld[i] = vld;
        end
        // Slot 0 is never read; an occupied zero key here catches stray reads.
        mem_key[0] = 8'h00;
        mem_vld[0] = 1'b1;
    endtask

    task automatic set(input int i, input logic [KW-1:0] key);
        mem_key[i] = key;
        mem_vld[i] = 1'b1;
    endtask

    task automatic issue(input logic [KW-1:0] k, input logic [W-1:0] ix,
                         input logic em, input logic [W-1:0] ct);
        exp_t e;
        e.key       = k;
        e.idx       = ix;
        e.empty     = em;
        e.count     = ct;
        e.start_cyc = cyc;
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: %0d results outstanding, 0 required", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        res_ready = 1'b1;
        fill(1'b0, 8'h05);
        repeat (3) tick();

        chk("rst_busy", busy, 0);
        chk("rst_cnt_enb", cnt_enb, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_key", res_key, 8'hFF);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_empty", res_empty, 0);
`ifdef PQ_SCAN_COUNT_EN
        chk("rst_res_count", res_count, 0);
`endif
        rst = 1'b1;
        tick();

        // Reset in the middle of a scan.
        fill(1'b0, 8'h05);
        set(4, 8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_scan_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_key", res_key, 8'hFF);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Only entry 9 occupied.
        fill(1'b0, 8'h05);
        set(9, 8'h42);
        issue(8'h42, 4'd9, 1'b0, 4'd1);
        wait_drain();

        // Everything empty.
        fill(1'b0, 8'h05);
        issue(8'hFF, 4'd0, 1'b1, 4'd0);
        wait_drain();

        // Tie between 3 and 12 keeps the lower index.
        fill(1'b1, 8'h80);
        set(3, 8'h10);
        set(12, 8'h10);
        issue(8'h10, 4'd3, 1'b0, 4'd15);
        wait_drain();

        // Winner in the final slot goes through the drain phase.
        set(15, 8'h01);
        issue(8'h01, 4'd15, 1'b0, 4'd15);
        wait_drain();

        // Back-pressure in DONE with stray start pulses.
        fill(1'b0, 8'h05);
        set(2, 8'h34);
        set(7, 8'h33);
        res_ready = 1'b0;
        issue(8'h33, 4'd7, 1'b0, 4'd2);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) break;
            tick();
        end
        chk("bp_valid_seen", res_valid, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        res_ready = 1'b1;
        wait_drain();
        repeat (25) tick();
        chk("bp_no_second_valid", res_valid, 0);
        chk("bp_idle_busy", busy, 0);

        // Seven occupied entries, then an immediate second scan.
        fill(1'b0, 8'h05);
        set(1, 8'h90);
        set(2, 8'h31);
        set(4, 8'h22);
        set(6, 8'h45);
        set(8, 8'h19);
        set(10, 8'h07);
        set(14, 8'h08);
        issue(8'h07, 4'd10, 1'b0, 4'd7);
        wait_drain();
        fill(1'b0, 8'h05);
        set(5, 8'h20);
        set(11, 8'h1F);
        set(13, 8'h1F);
        issue(8'h1F, 4'd11, 1'b0, 4'd3);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
